nios2_oci_dct_packer: RTL and testbench

- Sequencing controller for the OCI debug-capture trace buffer.
- Accepts 2-bit trace atoms from the OCI trace source and packs them into the 30-bit capture buffer with a 4-bit fill count.
- Emits full or partial words to the downstream trace sink over a valid/ready handshake.
- Runs the end-of-test flush: drains the residual atoms, then raises test_has_ended for the simulation bench.

---
 rtl/nios2_oci_dct_packer.sv | 121 ++++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_dct_packer.sv
// Trace-atom packer for the OCI debug-capture buffer: packs ATOM_W-bit atoms
// into SLOTS-slot words, emits them over valid/ready, and runs the end-of-test drain.
module nios2_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  output logic                      atom_ready,
  input  logic                      flush_req,
  input  logic                      test_ending,
  output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      word_valid,
  output logic [ATOM_W*SLOTS-1:0]   word_data,
  output logic [CNT_W-1:0]          word_count,
  input  logic                      word_ready,
  output logic                      test_has_ended
);

  localparam int BUF_W = ATOM_W * SLOTS;

  typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d;
  logic [CNT_W-1:0]   dct_count_q, dct_count_d;
  logic               word_valid_q, word_valid_d;
  logic [BUF_W-1:0]   word_data_q, word_data_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic               ending_pend_q, ending_pend_d;

  logic               accept;
  logic               ending;
  logic               full;
  logic [BUF_W-1:0]   buf_after;
  logic [CNT_W-1:0]   cnt_after;

  assign atom_ready     = (state_q == FILL) && !ending_pend_q;
  assign test_has_ended = (state_q == DONE);
  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign word_valid     = word_valid_q;
  assign word_data      = word_data_q;
  assign word_count     = word_count_q;

  always_comb begin
    state_d       = state_q;
    dct_buffer_d  = dct_buffer_q;
    dct_count_d   = dct_count_q;
    word_valid_d  = word_valid_q;
    word_data_d   = word_data_q;
    word_count_d  = word_count_q;
    ending_pend_d = ending_pend_q;
    accept        = 1'b0;
    full          = 1'b0;
    buf_after     = dct_buffer_q;
    cnt_after     = dct_count_q;
    ending        = ending_pend_q | test_ending;

    case (state_q)
      FILL: begin
        accept = atom_valid & atom_ready;
        // Unused upper slots are always zero, so OR-in is an exact slot write.
        if (accept) begin
          buf_after = dct_buffer_q | (BUF_W'(atom_data) << (ATOM_W * dct_count_q));
        end
        cnt_after     = dct_count_q + CNT_W'(accept);
        full          = (cnt_after == CNT_W'(SLOTS));
        ending_pend_d = ending;
        if (full || ((flush_req || ending) && (cnt_after != '0))) begin
          word_valid_d = 1'b1;
          word_data_d  = buf_after;
          word_count_d = cnt_after;
          dct_buffer_d = '0;
          dct_count_d  = '0;
          state_d      = EMIT;
        end else begin
          dct_buffer_d = buf_after;
          dct_count_d  = cnt_after;
          if (ending) state_d = DONE;
        end
      end
      EMIT: begin
        ending_pend_d = ending;
        if (word_ready) begin
          word_valid_d = 1'b0;
          word_data_d  = '0;
          word_count_d = '0;
          state_d      = ending_pend_q ? DONE : FILL;
        end
      end
      DONE: ;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= FILL;
      dct_buffer_q  <= '0;
      dct_count_q   <= '0;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_count_q  <= '0;
      ending_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dct_buffer_q  <= dct_buffer_d;
      dct_count_q   <= dct_count_d;
      word_valid_q  <= word_valid_d;
      word_data_q   <= word_data_d;
      word_count_q  <= word_count_d;
      ending_pend_q <= ending_pend_d;
    end
  end

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush_req;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic [29:0] word_data;
  logic [3:0]  word_count;
  logic        word_ready;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  nios2_oci_dct_packer #(.ATOM_W(2), .SLOTS(15), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush_req(flush_req), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .word_valid(word_valid), .word_data(word_data), .word_count(word_count),
    .word_ready(word_ready), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  // Reference model: atoms held, the word on offer, and end-of-test flags.
  logic [1:0] m_atoms[$];
  logic [1:0] m_word[$];
  bit         m_word_valid;
  bit         m_pend;
  bit         m_ended;

  function automatic logic [29:0] pack_atoms(input logic [1:0] q[$]);
    logic [29:0] v = '0;
    foreach (q[i]) v = v + (30'(q[i]) << (2 * i));
    return v;
  endfunction

  function automatic bit m_ready();
    return !m_word_valid && !m_pend && !m_ended;
  endfunction

  task automatic model_step(input bit av, input logic [1:0] ad, input bit fr,
                            input bit te, input bit wr);
    bit ending;
    if (m_ended) return;
    if (m_word_valid) begin
      if (wr) begin
        m_word_valid = 0;
        m_word.delete();
        if (m_pend) m_ended = 1;
      end
      if (te) m_pend = 1;
      return;
    end
    if (av && m_ready()) m_atoms.push_back(ad);
    ending = m_pend || te;
    if (te) m_pend = 1;
    if (m_atoms.size() == 15 || ((fr || ending) && m_atoms.size() > 0)) begin
      m_word = m_atoms;
      m_atoms.delete();
      m_word_valid = 1;
    end else if (ending) begin
      m_ended = 1;
    end
  endtask

  task automatic cycle(input bit av, input logic [1:0] ad, input bit fr,
                       input bit te, input bit wr);
    atom_valid = av; atom_data = ad; flush_req = fr; test_ending = te; word_ready = wr;
    model_step(av, ad, fr, te, wr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    atom_valid = 0; atom_data = '0; flush_req = 0; test_ending = 0; word_ready = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_atoms.delete(); m_word.delete();
    m_word_valid = 0; m_pend = 0; m_ended = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({word_valid, word_data, word_count, dct_buffer, dct_count, test_has_ended} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wv=%0b wd=%h wc=%0d buf=%h cnt=%0d end=%0b, want all 0",
               word_valid, word_data, word_count, dct_buffer, dct_count, test_has_ended);
    end
    checks++;
    if (atom_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b want 1", atom_ready);
    end
  endtask

  task automatic test_full_word();
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1, 2'b01, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 30'h15555555 || word_count !== 4'd15 || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL full_word: got wv=%0b wd=%h wc=%0d cnt=%0d, want 1 15555555 15 0",
               word_valid, word_data, word_count, dct_count);
    end
    cycle(0, 2'b00, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0 || word_count !== 4'd0 || atom_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_resume: got wv=%0b wc=%0d rdy=%0b, want 0 0 1", word_valid, word_count, atom_ready);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 2'b11, 0, 0, 0);
    cycle(1, 2'b10, 0, 0, 0);
    cycle(1, 2'b01, 0, 0, 0);
    cycle(0, 2'b00, 1, 0, 0);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 30'h0000001B || word_count !== 4'd3) begin
      errors++;
      $display("FAIL flush_word: got wv=%0b wd=%h wc=%0d, want 1 0000001b 3", word_valid, word_data, word_count);
    end
    cycle(0, 2'b00, 0, 0, 1);
    cycle(0, 2'b00, 1, 0, 0);
    checks++;
    if (word_valid !== 1'b0 || word_count !== 4'd0 || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL flush_empty: got wv=%0b wc=%0d cnt=%0d, want 0 0 0", word_valid, word_count, dct_count);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [29:0] exp;
    logic [1:0]  a;
    do_reset();
    exp = '0;
    for (int i = 0; i < 15; i++) begin
      a = 2'($urandom);
      exp = exp | (30'(a) << (2 * i));
      cycle(1, a, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (word_valid !== 1'b1 || word_data !== exp || word_count !== 4'd15 || atom_ready !== 1'b0 || dct_count !== 4'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got wv=%0b wd=%h wc=%0d rdy=%0b cnt=%0d, want 1 %h 15 0 0",
                 i, word_valid, word_data, word_count, atom_ready, dct_count, exp);
      end
      cycle(1, 2'b11, 1, 0, 0);
    end
    checks++;
    if (word_valid !== 1'b1 || word_data !== exp) begin
      errors++; $display("FAIL stall_last: got wv=%0b wd=%h, want 1 %h", word_valid, word_data, exp);
    end
    cycle(0, 2'b00, 0, 0, 1);
    checks++;
    if (atom_ready !== 1'b1 || word_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got rdy=%0b wv=%0b, want 1 0", atom_ready, word_valid);
    end
  endtask

  task automatic test_ending_flush();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 2'b10, 0, 0, 0);
    cycle(1, 2'b11, 0, 1, 0);
    checks++;
    if (word_valid !== 1'b1 || word_count !== 4'd8 || word_data !== 30'h0000EAAA || atom_ready !== 1'b0) begin
      errors++;
      $display("FAIL ending_word: got wv=%0b wc=%0d wd=%h rdy=%0b, want 1 8 0000eaaa 0",
               word_valid, word_count, word_data, atom_ready);
    end
    cycle(0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (test_has_ended !== 1'b1 || atom_ready !== 1'b0 || word_valid !== 1'b0) begin
        errors++;
        $display("FAIL ending_done[%0d]: got end=%0b rdy=%0b wv=%0b, want 1 0 0", i, test_has_ended, atom_ready, word_valid);
      end
      cycle(1, 2'b01, 1, 1, 1);
    end
  endtask

  task automatic test_ending_empty();
    do_reset();
    cycle(0, 2'b00, 0, 1, 0);
    checks++;
    if (test_has_ended !== 1'b1 || word_valid !== 1'b0 || atom_ready !== 1'b0) begin
      errors++;
      $display("FAIL ending_empty: got end=%0b wv=%0b rdy=%0b, want 1 0 0", test_has_ended, word_valid, atom_ready);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [29:0] exp;
    logic [1:0]  a;
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1, 2'b11, 0, 0, 0);
    do_reset();
    checks++;
    if ({word_valid, word_data, word_count, dct_buffer, dct_count, test_has_ended} !== '0 || atom_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_emit: got wv=%0b wd=%h wc=%0d buf=%h cnt=%0d rdy=%0b, want 0 0 0 0 0 1",
               word_valid, word_data, word_count, dct_buffer, dct_count, atom_ready);
    end
    exp = '0;
    for (int i = 0; i < 15; i++) begin
      a = 2'($urandom);
      exp = exp | (30'(a) << (2 * i));
      cycle(1, a, 0, 0, 0);
    end
    checks++;
    if (word_valid !== 1'b1 || word_data !== exp || word_count !== 4'd15) begin
      errors++;
      $display("FAIL reset_repack: got wv=%0b wd=%h wc=%0d, want 1 %h 15", word_valid, word_data, word_count, exp);
    end
  endtask

  task automatic test_random();
    bit av, fr, te, wr;
    logic [29:0] exp_wd;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (m_ended && $urandom_range(0, 3) == 0) do_reset();
      av = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 9) == 0);
      te = ($urandom_range(0, 149) == 0);
      wr = ($urandom_range(0, 1) == 1);
      cycle(av, 2'($urandom), fr, te, wr);
      exp_wd = m_word_valid ? pack_atoms(m_word) : 30'h0;
      checks++;
      if (word_valid !== m_word_valid || word_count !== 4'(m_word.size()) || (m_word_valid && word_data !== exp_wd)) begin
        errors++;
        $display("FAIL rand_word[%0d]: got wv=%0b wc=%0d wd=%h, want %0b %0d %h",
                 n, word_valid, word_count, word_data, m_word_valid, m_word.size(), exp_wd);
      end
      checks++;
      if (dct_count !== 4'(m_atoms.size()) || dct_buffer !== pack_atoms(m_atoms)) begin
        errors++;
        $display("FAIL rand_buf[%0d]: got cnt=%0d buf=%h, want %0d %h",
                 n, dct_count, dct_buffer, m_atoms.size(), pack_atoms(m_atoms));
      end
      checks++;
      if (atom_ready !== m_ready() || test_has_ended !== m_ended) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got rdy=%0b end=%0b, want %0b %0b",
                 n, atom_ready, test_has_ended, m_ready(), m_ended);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    atom_valid = 0; atom_data = '0; flush_req = 0; test_ending = 0; word_ready = 0;
    #2;
    test_reset();
    test_full_word();
    test_flush();
    test_back_to_back_stall();
    test_ending_flush();
    test_ending_empty();
    test_reset_mid_emit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
